// File: rtl/din_fifo_pkg.sv
// Shared types and saturating-add helpers for the offset-and-saturate sample FIFO.
// Arithmetic is done in a wide signed type so any legal output wordlength fits.
package din_fifo_pkg;

    localparam int SAT_W = 64;
    localparam int DEFAULT_DIN_OFFSET = 32768;

    typedef logic signed [SAT_W-1:0] wide_t;

    typedef struct packed {
        wide_t val;
        logic  sat;
    } sat_res_t;

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    function automatic sat_res_t sat_add(
        input wide_t a,
        input wide_t b,
        input int    w
    );
        wide_t    s;
        sat_res_t r;
        s     = a + b;
        r.sat = 1'b1;
        if (s > sat_max(w)) begin
            r.val = sat_max(w);
        end else if (s < sat_min(w)) begin
            r.val = sat_min(w);
        end else begin
            r.val = s;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/din_fifo_sat_ram.sv
// Generic 1-write/1-read register array for the sample FIFO.
// Synchronous write, combinational read.
module din_fifo_sat_ram
    import din_fifo_pkg::*;
#(
    parameter int LOG2_DEPTH = 2,
    parameter int WIDTH      = 18
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [LOG2_DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [LOG2_DEPTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [1 << LOG2_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/din_fifo_sat.sv
// Input-sample FIFO with write-time DC offset, saturation, fill level and flush.
// Define DIN_FIFO_STATS_EN to add the WR_COUNT / SAT_COUNT statistics outputs.
module din_fifo_sat
    import din_fifo_pkg::*;
#(
    parameter int LOG2_DEPTH      = 2,
    parameter int DIN_WORDLENGTH  = 16,
    parameter int DOUT_WORDLENGTH = 18,
    parameter logic signed [DOUT_WORDLENGTH-1:0] DIN_OFFSET =
        DOUT_WORDLENGTH'(DEFAULT_DIN_OFFSET),
    parameter int AFULL_THRESH    = 3
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              FLUSH,
    input  logic                              DIN_IN_RTS,
    output logic                              DIN_IN_RTR,
    input  logic signed [DIN_WORDLENGTH-1:0]  DIN_DAT,
    output logic                              DIN_OUT_RTS,
    input  logic                              DIN_OUT_RTR,
    output logic signed [DOUT_WORDLENGTH-1:0] DOUT_DAT,
    output logic [LOG2_DEPTH:0]               FILL,
    output logic                              AFULL,
`ifdef DIN_FIFO_STATS_EN
    output logic [31:0]                       WR_COUNT,
    output logic [15:0]                       SAT_COUNT,
    output logic                              SAT_FLAG
`else
    output logic                              SAT_FLAG
`endif
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH_F  = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] THRESH_F = (LOG2_DEPTH + 1)'(AFULL_THRESH);

    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 8) begin : g_bad_depth
        $error("din_fifo_sat: LOG2_DEPTH must be 1..8");
    end
    if (DOUT_WORDLENGTH < DIN_WORDLENGTH) begin : g_bad_width
        $error("din_fifo_sat: DOUT_WORDLENGTH < DIN_WORDLENGTH");
    end
    if (DOUT_WORDLENGTH > SAT_W - 2) begin : g_too_wide
        $error("din_fifo_sat: DOUT_WORDLENGTH too large");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("din_fifo_sat: AFULL_THRESH out of range");
    end

    logic [LOG2_DEPTH:0]          fill;
    logic [LOG2_DEPTH-1:0]        wptr;
    logic [LOG2_DEPTH-1:0]        rptr;
    logic                         sat_flag;
    logic                         in_xfc;
    logic                         out_xfc;
    sat_res_t                     wr_res;
    logic [DOUT_WORDLENGTH-1:0]   wr_data;
    logic                         unused_hi;

    // Both handshakes are forced low during reset and flush so nothing moves.
    assign DIN_IN_RTR  = (fill < DEPTH_F) & ~RESET & ~FLUSH;
    assign DIN_OUT_RTS = (fill != '0) & ~RESET & ~FLUSH;
    assign in_xfc      = DIN_IN_RTS & DIN_IN_RTR;
    assign out_xfc     = DIN_OUT_RTS & DIN_OUT_RTR;

    assign wr_res    = sat_add(wide_t'(DIN_DAT), wide_t'(DIN_OFFSET),
                               DOUT_WORDLENGTH);
    assign wr_data   = wr_res.val[DOUT_WORDLENGTH-1:0];
    assign unused_hi = ^wr_res.val[SAT_W-1:DOUT_WORDLENGTH];

    din_fifo_sat_ram #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .WIDTH      (DOUT_WORDLENGTH)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (in_xfc),
        .wr_addr (wptr),
        .wr_data (wr_data),
        .rd_addr (rptr),
        .rd_data (DOUT_DAT)
    );

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            fill     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (in_xfc) begin
                wptr <= wptr + 1'b1;
            end
            if (out_xfc) begin
                rptr <= rptr + 1'b1;
            end
            if (in_xfc && !out_xfc) begin
                fill <= fill + 1'b1;
            end else if (out_xfc && !in_xfc) begin
                fill <= fill - 1'b1;
            end
            if (in_xfc && wr_res.sat) begin
                sat_flag <= 1'b1;
            end
        end
    end

    assign FILL     = fill;
    assign AFULL    = (fill >= THRESH_F);
    assign SAT_FLAG = sat_flag;

`ifdef DIN_FIFO_STATS_EN
    // Statistics survive FLUSH; only RESET clears them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WR_COUNT  <= '0;
            SAT_COUNT <= '0;
        end else if (in_xfc) begin
            WR_COUNT <= WR_COUNT + 32'd1;
            if (wr_res.sat && SAT_COUNT != 16'hFFFF) begin
                SAT_COUNT <= SAT_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_din_fifo_sat.sv
// Self-checking bench for din_fifo_sat: scoreboard on the default instance,
// two extra instances with extreme offsets exercise saturation and flush.
module tb_din_fifo_sat;

    localparam longint OFF  = 32768;
    localparam longint SMAX = 131071;
    localparam longint SMIN = -131072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, flush, rts_in, rtr_out;
    logic signed [15:0] din;
    logic               rtr_in, rts_out, afull, sat;
    logic signed [17:0] dout;
    logic [2:0]         fill;

    logic               s_rts, s_flush, s_rtr;
    logic signed [15:0] h_din, l_din;
    logic               h_rtr, h_rts, h_afull, h_sat;
    logic               l_rtr, l_rts, l_afull, l_sat;
    logic signed [17:0] h_dout, l_dout;
    logic [2:0]         h_fill, l_fill;

`ifdef DIN_FIFO_STATS_EN
    logic [31:0] wrc [3];
    logic [15:0] satc [3];
`endif

    din_fifo_sat #(
        .LOG2_DEPTH(2), .DIN_WORDLENGTH(16), .DOUT_WORDLENGTH(18),
        .DIN_OFFSET(18'sd32768), .AFULL_THRESH(3)
    ) dut (
        .CLK(clk), .RESET(rst), .FLUSH(flush),
        .DIN_IN_RTS(rts_in), .DIN_IN_RTR(rtr_in), .DIN_DAT(din),
        .DIN_OUT_RTS(rts_out), .DIN_OUT_RTR(rtr_out), .DOUT_DAT(dout),
        .FILL(fill), .AFULL(afull),
`ifdef DIN_FIFO_STATS_EN
        .WR_COUNT(wrc[0]), .SAT_COUNT(satc[0]),
`endif
        .SAT_FLAG(sat)
    );

    din_fifo_sat #(.DIN_OFFSET(18'sh1FFFF)) dut_hi (
        .CLK(clk), .RESET(rst), .FLUSH(s_flush),
        .DIN_IN_RTS(s_rts), .DIN_IN_RTR(h_rtr), .DIN_DAT(h_din),
        .DIN_OUT_RTS(h_rts), .DIN_OUT_RTR(s_rtr), .DOUT_DAT(h_dout),
        .FILL(h_fill), .AFULL(h_afull),
`ifdef DIN_FIFO_STATS_EN
        .WR_COUNT(wrc[1]), .SAT_COUNT(satc[1]),
`endif
        .SAT_FLAG(h_sat)
    );

    din_fifo_sat #(.DIN_OFFSET(18'sh20000)) dut_lo (
        .CLK(clk), .RESET(rst), .FLUSH(s_flush),
        .DIN_IN_RTS(s_rts), .DIN_IN_RTR(l_rtr), .DIN_DAT(l_din),
        .DIN_OUT_RTS(l_rts), .DIN_OUT_RTR(s_rtr), .DOUT_DAT(l_dout),
        .FILL(l_fill), .AFULL(l_afull),
`ifdef DIN_FIFO_STATS_EN
        .WR_COUNT(wrc[2]), .SAT_COUNT(satc[2]),
`endif
        .SAT_FLAG(l_sat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_sum(input longint d);
        longint s;
        s = d + OFF;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    function automatic bit ref_clamp(input longint d);
        return (d + OFF > SMAX) || (d + OFF < SMIN);
    endfunction

    // Scoreboard: push on accepted write, pop and compare on accepted read.
    logic signed [17:0] sb_q [$];
    bit mon_en = 1'b0;
    bit model_sat = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("fill", fill, sb_q.size());
            chk("afull", afull, sb_q.size() >= 3);
            chk("rtr", rtr_in, (sb_q.size() < 4) && !rst && !flush);
            chk("rts", rts_out, (sb_q.size() > 0) && !rst && !flush);
            chk("sat", sat, model_sat);
            if (rst || flush) begin
                sb_q.delete();
                model_sat = 1'b0;
            end else begin
                if (rts_out && rtr_out && sb_q.size() > 0) begin
                    chk("dout", dout, sb_q.pop_front());
                end
                if (rts_in && rtr_in) begin
                    sb_q.push_back(18'(ref_sum(longint'(din))));
                    if (ref_clamp(longint'(din))) model_sat = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rtr_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fill == 3'd0) break;
            step();
        end
        chk("drain_empty", fill, 0);
        step();
        rtr_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic signed [17:0] a_exp [3];

    initial begin
        rst = 1'b1; flush = 1'b0; rts_in = 1'b0; rtr_out = 1'b0; din = '0;
        s_rts = 1'b0; s_flush = 1'b0; s_rtr = 1'b0;
        h_din = '0; l_din = '0;
        a_exp[0] = 18'sd0; a_exp[1] = 18'sd32768; a_exp[2] = 18'sd65535;

        repeat (2) step();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_afull", afull, 0);
        chk("rst_rtr", rtr_in, 0);
        chk("rst_rts", rts_out, 0);
        chk("rst_hsat", h_sat, 0);
        step();
        rst = 1'b0;

        // Three writes with the reader stalled, then drain in order.
        rts_in = 1'b1;
        din = -16'sd32768; step();
        din = 16'sd0;      step();
        din = 16'sd32767;  step();
        rts_in = 1'b0;
        @(negedge clk);
        chk("a_fill", fill, 3);
        chk("a_afull", afull, 1);
        step();
        rtr_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_dout", dout, a_exp[i]);
            chk("a_sat", sat, 0);
            step();
        end
        rtr_out = 1'b0;

        // Saturation at both rails, then flush clears the sticky flag.
        s_rts = 1'b1; h_din = 16'sd100; l_din = -16'sd1;
        step();
        s_rts = 1'b0;
        @(negedge clk);
        chk("hi_dout", h_dout, SMAX);
        chk("hi_sat", h_sat, 1);
        chk("lo_dout", l_dout, SMIN);
        chk("lo_sat", l_sat, 1);
        step();
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        @(negedge clk);
        chk("hi_flush_sat", h_sat, 0);
        chk("hi_flush_fill", h_fill, 0);
        chk("lo_flush_rts", l_rts, 0);
        step();

        // Fill to full with RTS held, then read at full.
        rts_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 16'(i * 100 - 250);
            step();
        end
        @(negedge clk);
        chk("b_fill", fill, 4);
        chk("b_rtr", rtr_in, 0);
        step();
        rtr_out = 1'b1;
        @(negedge clk);
        chk("b_rtr_rd", rtr_in, 0);
        step();
        rtr_out = 1'b0;
        rts_in = 1'b0;
        @(negedge clk);
        chk("b_fill_rd", fill, 3);
        step();
        drain();

        // Steady state at FILL=2 with both sides moving every cycle.
        rts_in = 1'b1;
        din = 16'sd1000; step();
        din = 16'sd1001; step();
        rtr_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 16'(2000 + i * 37);
            @(negedge clk);
            chk("d_fill", fill, 2);
            step();
        end
        rts_in = 1'b0;
        drain();

        // Flush with a write pending.
        rts_in = 1'b1;
        din = 16'sd5; step();
        din = 16'sd6; step();
        din = 16'sd7; step();
        flush = 1'b1; din = 16'sd8;
        @(negedge clk);
        chk("e_rtr", rtr_in, 0);
        step();
        flush = 1'b0; rts_in = 1'b0;
        @(negedge clk);
        chk("e_fill", fill, 0);
        chk("e_rts", rts_out, 0);
        step();

        // Reset mid-drain, then the next write is the first read.
        rts_in = 1'b1;
        din = 16'sd11; step();
        din = 16'sd12; step();
        din = 16'sd13; step();
        rts_in = 1'b0; rtr_out = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("f_rtr", rtr_in, 0);
        chk("f_rts", rts_out, 0);
        step();
        @(negedge clk);
        chk("f_fill", fill, 0);
        step();
        rst = 1'b0; rtr_out = 1'b0; rts_in = 1'b1; din = -16'sd1234;
        step();
        rts_in = 1'b0; rtr_out = 1'b1;
        @(negedge clk);
        chk("f_first", dout, 31534);
        step();
        rtr_out = 1'b0;
        @(negedge clk);
        chk("f_empty", fill, 0);

        chk("sb_left", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
